c_tile_drain: RTL and testbench
===============================

# c_tile_drain

Readout engine placed directly downstream of the C-result SRAM wrapper. After a tile completes, it walks all M×N entries in row-major order through the wrapper's single-word C read port. Results go onto a valid/ready stream tagged with (row, col) and a last marker, and the engine throttles reads against downstream backpressure through a small internal FIFO.

## Interface
- M, 8, rows of C tile
- N, 8, columns of C tile
- DATA_W, 32, word width (FP32)
- ROW_W, (M<=1)?1:$clog2(M), row index width
- COL_W, (N<=1)?1:$clog2(N), column index width
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥2)

- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  one-cycle drain request
- c_valid_i  in  1  wrapper C_valid: SRAM holds a complete tile
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse after last beat accepted downstream
- c_rd_en, c_rd_re  out  1 each  read request to wrapper (always driven equal)
- c_rd_row  out  ROW_W  request row
- c_rd_col  out  COL_W  request column
- c_rd_rdata  in  DATA_W  read data, qualified by c_rd_rvalid
- c_rd_rvalid  in  1  read response valid
- m_valid  out  1  stream beat valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  C element
- m_row  out  ROW_W  element row
- m_col  out  COL_W  element column
- m_last  out  1  high on beat (M-1, N-1)

## Operation
- FSM states: IDLE, WAIT_CV, REQ, GAP, FLUSH, DONE.
- IDLE: start=1 → WAIT_CV. Indices reset to (0,0). start in any other state is ignored.
- WAIT_CV: c_valid_i=1 and credit available → REQ.
- Credit rule: FIFO occupancy + 1 ≤ FIFO_DEPTH. Only one read is outstanding at a time.
- REQ: c_rd_en=c_rd_re=1. row/col stay stable until c_rd_rvalid is sampled high. On that cycle, push {rdata,row,col,last} into the FIFO and advance the index (col+1; at col=N-1 wrap to 0 and row+1) → GAP.
- GAP: en/re=0. Wait until c_rd_rvalid is sampled low. Then: if the element just read was the last one → FLUSH; else if credit is available → REQ; else stay in GAP.
- FLUSH: wait until the FIFO is empty, i.e. the last beat was accepted (m_valid & m_ready & m_last) → DONE.
- DONE: done=1 for one cycle → IDLE.
- busy=1 in every state except IDLE.
- FIFO: push and pop in the same cycle are allowed when full or empty. m_* is driven from the FIFO head. m_valid=!empty.
- m_* stays stable while m_valid & !m_ready.
- c_rd_rvalid outside REQ is ignored (no push).
- c_valid_i dropping mid-drain has no effect; the drain completes.

## Timing
- Reset: busy, done, c_rd_en, c_rd_re, m_valid, m_last = 0; c_rd_row, c_rd_col, m_data, m_row, m_col = 0. FIFO is emptied and the FSM goes to IDLE.
- Reset mid-drain aborts immediately: no done, queued beats are discarded.
- All outputs are registered.
- start sampled at edge t with c_valid_i=1 → c_rd_en high from t+2 (through WAIT_CV).
- rvalid sampled at edge u → the beat is visible on m_valid at u+1, and c_rd_en=0 at u+1.
- With SRAM latency 1 and m_ready=1: one element per 3 cycles (REQ, rvalid, GAP).
- done asserts the cycle after FLUSH sees the FIFO empty. It is never concurrent with m_valid.

## Configuration
- C_DRAIN_RELU_EN defined: any word with sign bit 1 (including -0.0 and negative NaN) is replaced by 32'h00000000 on push. Positive values are unchanged.
- Undefined: m_data equals c_rd_rdata bit-exactly.

## Test plan
- Basic drain, 8×8: latency-1 stub SRAM returns {24'h0,row,col}, m_ready=1. Expect 64 beats in row-major order with m_row/m_col matching data, m_last only on beat 64 at (7,7), exactly one done pulse, busy falling with done.
- Backpressure: m_ready=0 for 30 cycles starting after beat 2. Expect c_rd_en to stay low once the FIFO holds 4 entries, no beat lost or duplicated, and the stream to resume in order.
- Start before tile ready: start while c_valid_i=0, then raise c_valid_i 10 cycles later. Expect no c_rd_en during the wait and the first request 2 cycles after c_valid_i rises. A second start while busy is ignored.
- Variable SRAM latency of 1–5 cycles, with rvalid held 2 cycles per response. Expect each element pushed once and the next request only after rvalid drops.
- Reset mid-drain: assert rst_n=0 after beat 20. Expect all outputs 0 the next cycle and no done. A fresh start afterwards drains all 64 elements from (0,0).
- Stub returns 32'hC0000000 at (3,5). Expect m_data=0 with C_DRAIN_RELU_EN defined and 32'hC0000000 without it.

Source files
------------

// File: rtl/c_tile_drain_if.sv
// Bundle of the C-SRAM read port and the (row,col)-tagged result stream.
// master = drain engine side, slave = SRAM wrapper / downstream consumer side.
interface c_tile_drain_if #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 3,
  parameter int COL_W  = 3
);
  logic              c_rd_en;
  logic              c_rd_re;
  logic [ROW_W-1:0]  c_rd_row;
  logic [COL_W-1:0]  c_rd_col;
  logic [DATA_W-1:0] c_rd_rdata;
  logic              c_rd_rvalid;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ROW_W-1:0]  m_row;
  logic [COL_W-1:0]  m_col;
  logic              m_last;

  modport master (
    output c_rd_en, c_rd_re, c_rd_row, c_rd_col,
    input  c_rd_rdata, c_rd_rvalid,
    output m_valid, m_data, m_row, m_col, m_last,
    input  m_ready
  );

  modport slave (
    input  c_rd_en, c_rd_re, c_rd_row, c_rd_col,
    output c_rd_rdata, c_rd_rvalid,
    input  m_valid, m_data, m_row, m_col, m_last,
    output m_ready
  );
endinterface

// File: rtl/c_tile_drain.sv
// Walks an MxN C tile in row-major order and streams it out through a small FIFO.
// Define C_DRAIN_RELU_EN to replace every sign-bit-set word with zero on push.
module c_tile_drain #(
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int DATA_W     = 32,
  parameter int ROW_W      = (M <= 1) ? 1 : $clog2(M),
  parameter int COL_W      = (N <= 1) ? 1 : $clog2(N),
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             c_valid_i,
  output logic             busy,
  output logic             done,
  c_tile_drain_if.master   bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = 1 + ROW_W + COL_W + DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_CV, S_REQ, S_GAP, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic              c_valid_q;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              last_rd_q, last_rd_d;
  logic [ENT_W-1:0]  slot_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  slot_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, wr_pos;
  logic              credit, at_last, push, pop;
  logic [DATA_W-1:0] word_in;
  logic [ENT_W-1:0]  entry_in;

  assign credit  = (cnt_q < CNT_W'(FIFO_DEPTH));
  assign at_last = (row_q == ROW_W'(M - 1)) && (col_q == COL_W'(N - 1));
  assign push    = (state_q == S_REQ) && bus.c_rd_rvalid;
  assign pop     = vld_q[0] && bus.m_ready;

`ifdef C_DRAIN_RELU_EN
  assign word_in = bus.c_rd_rdata[DATA_W-1] ? '0 : bus.c_rd_rdata;
`else
  assign word_in = bus.c_rd_rdata;
`endif
  assign entry_in = {at_last, row_q, col_q, word_in};

  // c_valid_i is registered so a late tile-ready costs the same two cycles as start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      c_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      c_valid_q <= c_valid_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_WAIT_CV;
      S_WAIT_CV: if (c_valid_q && credit) state_d = S_REQ;
      S_REQ:     if (bus.c_rd_rvalid) state_d = S_GAP;
      S_GAP: begin
        if (!bus.c_rd_rvalid) begin
          if (last_rd_q)   state_d = S_FLUSH;
          else if (credit) state_d = S_REQ;
        end
      end
      S_FLUSH:   if (cnt_q == '0) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decode the next state so they leave the flops already aligned with it.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    rd_en_d = (state_d == S_REQ);
  end

  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    last_rd_d = last_rd_q;
    if ((state_q == S_IDLE) && start) begin
      row_d     = '0;
      col_d     = '0;
      last_rd_d = 1'b0;
    end else if (push) begin
      last_rd_d = at_last;
      if (col_q == COL_W'(N - 1)) begin
        col_d = '0;
        row_d = at_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Shift-register FIFO: slot 0 is always the head, so m_* come straight from flops.
  always_comb begin
    wr_pos = pop ? cnt_q - CNT_W'(1) : cnt_q;
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_d[i] = slot_q[i];
      vld_d[i]  = vld_q[i];
    end
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        slot_d[i] = slot_q[i+1];
        vld_d[i]  = vld_q[i+1];
      end
      slot_d[FIFO_DEPTH-1] = '0;
      vld_d[FIFO_DEPTH-1]  = 1'b0;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (push && (wr_pos == CNT_W'(i))) begin
        slot_d[i] = entry_in;
        vld_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q     <= '0;
      col_q     <= '0;
      last_rd_q <= 1'b0;
      cnt_q     <= '0;
      vld_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) slot_q[i] <= '0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      last_rd_q <= last_rd_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      for (int i = 0; i < FIFO_DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign bus.c_rd_en  = rd_en_q;
  assign bus.c_rd_re  = rd_en_q;
  assign bus.c_rd_row = row_q;
  assign bus.c_rd_col = col_q;
  assign bus.m_valid  = vld_q[0];
  assign {bus.m_last, bus.m_row, bus.m_col, bus.m_data} = slot_q[0];
endmodule

// File: tb/tb_c_tile_drain.sv
// Directed-plus-random bench for c_tile_drain: SRAM stub with programmable latency,
// a row-major reference queue, and checks on every accepted beat.
module tb_c_tile_drain;
  localparam int M = 8, N = 8, DW = 32, RW = 3, CW = 3, DEPTH = 4;
`ifdef C_DRAIN_RELU_EN
  localparam logic [31:0] SPECIAL_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] SPECIAL_EXP = 32'hC000_0000;
`endif

  typedef struct {
    logic [31:0] data;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, c_valid_i, busy, done;
  c_tile_drain_if #(.DATA_W(DW), .ROW_W(RW), .COL_W(CW)) bus();

  c_tile_drain #(.M(M), .N(N), .DATA_W(DW), .ROW_W(RW), .COL_W(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c_valid_i(c_valid_i),
    .busy(busy), .done(done), .bus(bus)
  );

  int total = 0, bad = 0;
  int n_push = 0, n_acc = 0, done_cnt = 0, cyc = 0;
  int first_push_cyc = -1, last_push_cyc = -1;
  bit en_prev = 0, rv_prev = 0, special_on = 0;
  beat_t exp_q[$];
  beat_t mon_b;
  logic [31:0] tile [M][N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // SRAM stub: one response per request, latency lat_pick, rvalid held hold_n cycles.
  bit lat_rand = 0;
  int hold_n = 1, lat_cnt = 0, hold_cnt = 0, lat_pick = 1;
  logic stub_rv = 1'b0;
  logic [2:0] cap_r = 3'd0, cap_c = 3'd0;
  assign bus.c_rd_rvalid = stub_rv;
  assign bus.c_rd_rdata  = tile[cap_r][cap_c];

  always @(posedge clk) begin
    if (!rst_n) begin
      stub_rv <= 1'b0; lat_cnt <= 0; hold_cnt <= 0;
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
      if (hold_cnt == 1) stub_rv <= 1'b0;
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin stub_rv <= 1'b1; hold_cnt <= hold_n; end
    end else if (bus.c_rd_en && !stub_rv) begin
      cap_r <= bus.c_rd_row;
      cap_c <= bus.c_rd_col;
      lat_pick = lat_rand ? int'($urandom_range(1, 5)) : 1;
      if (lat_pick == 1) begin stub_rv <= 1'b1; hold_cnt <= hold_n; end
      else lat_cnt <= lat_pick - 1;
    end
  end

  // Monitor: beats vs reference queue, occupancy bound, request ordering, done pulses.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.c_rd_en && !en_prev) chk("req_after_rvalid_low", rv_prev, 0);
      if (bus.c_rd_en && bus.c_rd_rvalid) begin
        n_push++;
        if (first_push_cyc < 0) first_push_cyc = cyc;
        last_push_cyc = cyc;
        chk("re_eq_en", bus.c_rd_re, bus.c_rd_en);
        chk("fifo_occupancy", (n_push - n_acc - int'(bus.m_valid && bus.m_ready)) <= DEPTH, 1);
      end
      if (bus.m_valid && bus.m_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          mon_b = exp_q.pop_front();
          chk("beat_data", bus.m_data, mon_b.data);
          chk("beat_row", bus.m_row, mon_b.row);
          chk("beat_col", bus.m_col, mon_b.col);
          chk("beat_last", bus.m_last, mon_b.last);
          if (special_on && bus.m_row == 3'd3 && bus.m_col == 3'd5)
            chk("relu_3_5", bus.m_data, SPECIAL_EXP);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_no_mvalid", bus.m_valid, 0);
      end
      en_prev = bus.c_rd_en;
      rv_prev = bus.c_rd_rvalid;
    end else begin
      en_prev = 0;
      rv_prev = 0;
    end
  end

  function automatic logic [31:0] relu_exp(input logic [31:0] v);
`ifdef C_DRAIN_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  task automatic fill_tile(input int mode);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        tile[r][c] = (mode == 0) ? {24'h0, 1'b0, 3'(r), 1'b0, 3'(c)} : $urandom;
    if (mode == 1) tile[3][5] = 32'hC000_0000;
  endtask

  task automatic build_model();
    exp_q.delete();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        exp_q.push_back('{data: relu_exp(tile[r][c]), row: 3'(r), col: 3'(c),
                          last: (r == M - 1) && (c == N - 1)});
    n_push = 0;
    n_acc  = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 0);           chk("rst_done", done, 0);
    chk("rst_rd_en", bus.c_rd_en, 0);   chk("rst_rd_re", bus.c_rd_re, 0);
    chk("rst_rd_row", bus.c_rd_row, 0); chk("rst_rd_col", bus.c_rd_col, 0);
    chk("rst_m_valid", bus.m_valid, 0); chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_data", bus.m_data, 0);   chk("rst_m_row", bus.m_row, 0);
    chk("rst_m_col", bus.m_col, 0);
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (n_acc < n && k < budget) begin @(posedge clk); #1; k++; end
    chk(tag, k < budget, 1);
  endtask

  task automatic wait_done(input int budget, input bit rnd, input int base_done);
    int k = 0;
    while (done_cnt == base_done && k < budget) begin
      @(posedge clk); #1;
      if (rnd) bus.m_ready = ($urandom_range(0, 3) != 0);
      k++;
    end
    bus.m_ready = 1'b1;
    chk("done_timeout", k < budget, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    repeat (5) @(negedge clk);
    chk("done_count", done_cnt, base_done + 1);
    chk("all_beats_seen", exp_q.size(), 0);
    chk("beat_total", n_acc, M * N);
  endtask

  initial begin
    int base, en_seen;
    rst_n = 1'b0; start = 1'b0; c_valid_i = 1'b0; bus.m_ready = 1'b1;
    fill_tile(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic 8x8 drain, latency 1, always ready
    lat_rand = 0; hold_n = 1; c_valid_i = 1'b1;
    build_model();
    first_push_cyc = -1;
    repeat (2) @(posedge clk); #1;
    base = done_cnt;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); chk("t1_en_in_wait_cv", bus.c_rd_en, 0);
    @(negedge clk); chk("t1_en_first_req", bus.c_rd_en, 1);
    wait_done(2000, 0, base);
    chk("t1_three_cycle_rate", last_push_cyc - first_push_cyc, 3 * (M * N - 1));

    // Backpressure: stall downstream for 30 cycles after beat 2
    fill_tile(1); special_on = 1; build_model(); base = done_cnt;
    pulse_start();
    wait_beats(2, 500, "t2_first_beats_timeout");
    bus.m_ready = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("t2_no_req_when_full", bus.c_rd_en, 0);
    chk("t2_fifo_full", n_push - n_acc, DEPTH);
    chk("t2_mvalid_held", bus.m_valid, 1);
    chk("t2_accepted_stalled", n_acc, 2);
    @(posedge clk); #1 bus.m_ready = 1'b1;
    wait_done(2000, 0, base);
    special_on = 0;

    // Start before the tile is ready; second start and c_valid drop mid-drain
    c_valid_i = 1'b0; fill_tile(2); build_model(); base = done_cnt;
    pulse_start();
    en_seen = 0;
    repeat (10) begin @(negedge clk); if (bus.c_rd_en) en_seen++; end
    chk("t3_no_req_without_cvalid", en_seen, 0);
    chk("t3_busy_waiting", busy, 1);
    @(posedge clk); #1 c_valid_i = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("t3_en_cv_plus1", bus.c_rd_en, 0);
    @(negedge clk); chk("t3_en_cv_plus2", bus.c_rd_en, 1);
    wait_beats(5, 500, "t3_beats_timeout");
    @(posedge clk); #1 start = 1'b1; c_valid_i = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    wait_done(2000, 0, base);
    repeat (20) @(negedge clk);
    chk("t3_no_restart", n_acc, M * N);
    chk("t3_idle_after", busy, 0);
    c_valid_i = 1'b1;

    // Random latency 1..5, rvalid held 2 cycles, random backpressure
    lat_rand = 1; hold_n = 2; fill_tile(2); build_model(); base = done_cnt;
    pulse_start();
    wait_done(6000, 1, base);
    lat_rand = 0; hold_n = 1;

    // Reset mid-drain after beat 20, then a fresh full drain
    fill_tile(2); build_model(); base = done_cnt;
    pulse_start();
    wait_beats(20, 1000, "t5_beats_timeout");
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    exp_q.delete();
    repeat (10) @(negedge clk);
    chk("t5_no_done_after_abort", done_cnt, base);
    chk("t5_idle_after_abort", busy, 0);
    build_model(); base = done_cnt;
    pulse_start();
    wait_done(2000, 0, base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
